// File: rtl/chip8_regfile.sv
// chip8_regfile: CHIP-8 V0..VF register file, flag (VF) port, two registered read ports, FX55 dump sequencer.
// Latency: reads 1 cycle; first dump beat 1 cycle after dump_start, then one beat per accepted handshake.
// Backpressure: dump_idx/dump_data held while dump_valid && !dump_ready. REGFILE_BYPASS_EN forwards same-cycle writes.
module chip8_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_en,
    input  logic [DATA_W-1:0] flag_data,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_last,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] regs [NREGS];
    state_t            state;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_clip;

    // Value a read/dump load captures this edge; out-of-range indices read as 0.
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (int'(a) < NREGS) begin
`ifdef REGFILE_BYPASS_EN
            if (clr)
                v = '0;
            else if (flag_en && (int'(a) == NREGS - 1))
                v = flag_data;
            else if (wr_en && (wr_addr == a))
                v = wr_data;
            else
                v = regs[a];
`else
            v = regs[a];
`endif
        end
        return v;
    endfunction

    // Clamp the requested last dump index to the flag register.
    always_comb begin
        last_clip = dump_last;
        if (int'(dump_last) > NREGS - 1)
            last_clip = ADDR_W'(NREGS - 1);
    end

    // Register array update: clr beats flag write, flag write beats the general write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clr)
                    regs[i] <= '0;
                else if (flag_en && (i == NREGS - 1))
                    regs[i] <= flag_data;
                else if (wr_en && (int'(wr_addr) == i))
                    regs[i] <= wr_data;
            end
        end
    end

    // Registered read ports, sampled every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
        end else begin
            rd_a_data <= rd_val(rd_a_addr);
            rd_b_data <= rd_val(rd_b_addr);
        end
    end

    // Dump sequencer: streams V0..last one beat per handshake, pulses dump_done after the last beat; clr aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_q     <= '0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start && !clr) begin
                        state      <= SEND;
                        last_q     <= last_clip;
                        dump_idx   <= '0;
                        dump_data  <= rd_val('0);
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (clr) begin
                        state      <= IDLE;
                        dump_valid <= 1'b0;
                        dump_busy  <= 1'b0;
                    end else if (dump_ready) begin
                        if (dump_idx == last_q) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_idx  <= dump_idx + ADDR_W'(1);
                            dump_data <= rd_val(dump_idx + ADDR_W'(1));
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_regfile.sv
// tb_chip8_regfile: scoreboard bench for chip8_regfile (default 8x16 configuration).
// Latency: expected read/dump values are queued when stimulus is driven and popped when the DUT presents them.
// Backpressure: dump_ready is toggled to exercise beat hold, abort and reset-mid-dump.
module tb_chip8_regfile;
    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              flag_en = 1'b0;
    logic [DATA_W-1:0] flag_data = '0;
    logic [ADDR_W-1:0] rd_a_addr = '0;
    logic [ADDR_W-1:0] rd_b_addr = '0;
    logic              dump_start = 1'b0;
    logic [ADDR_W-1:0] dump_last = '0;
    logic              dump_ready = 1'b0;
    logic [DATA_W-1:0] rd_a_data, rd_b_data, dump_data;
    logic [ADDR_W-1:0] dump_idx;
    logic              dump_busy, dump_valid, dump_done;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0]        model [NREGS];
    logic [DATA_W-1:0]        exp_a_q [$];
    logic [DATA_W-1:0]        exp_b_q [$];
    logic [ADDR_W+DATA_W-1:0] exp_beat_q [$];

    chip8_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_en(flag_en), .flag_data(flag_data),
        .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .dump_start(dump_start), .dump_last(dump_last),
        .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset;
        logic [DATA_W-1:0] e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_a_data !== 8'h00 || rd_b_data !== 8'h00 || dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h b=%h busy=%b valid=%b done=%b want all 0", rd_a_data, rd_b_data, dump_busy, dump_valid, dump_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 0; i < NREGS; i++) begin
            rd_a_addr = ADDR_W'(i);
            rd_b_addr = ADDR_W'(NREGS - 1 - i);
            exp_a_q.push_back(model[i]);
            exp_b_q.push_back(model[NREGS - 1 - i]);
            tick();
            e = exp_a_q.pop_front();
            checks++;
            if (rd_a_data !== e) begin failures++; $display("FAIL reset_rd_a[%0d] got %h want %h", i, rd_a_data, e); end
            e = exp_b_q.pop_front();
            checks++;
            if (rd_b_data !== e) begin failures++; $display("FAIL reset_rd_b[%0d] got %h want %h", NREGS - 1 - i, rd_b_data, e); end
        end
    endtask

    task automatic test_write_read;
        logic [DATA_W-1:0] e;
        write_reg(3, 8'hA5);
        rd_a_addr = 4'd3; rd_b_addr = 4'd4;
        exp_a_q.push_back(model[3]);
        exp_b_q.push_back(model[4]);
        tick();
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL wr_rd_v3 got %h want %h", rd_a_data, e); end
        e = exp_b_q.pop_front();
        checks++;
        if (rd_b_data !== e) begin failures++; $display("FAIL wr_rd_v4 got %h want %h", rd_b_data, e); end
        for (int i = 0; i < NREGS; i++) write_reg(i, 8'(i * 37 + 5));
        for (int i = 0; i < NREGS; i++) begin
            rd_a_addr = ADDR_W'(i);
            rd_b_addr = ADDR_W'((i + 7) % NREGS);
            exp_a_q.push_back(model[i]);
            exp_b_q.push_back(model[(i + 7) % NREGS]);
            tick();
            e = exp_a_q.pop_front();
            checks++;
            if (rd_a_data !== e) begin failures++; $display("FAIL pattern_rd_a[%0d] got %h want %h", i, rd_a_data, e); end
            e = exp_b_q.pop_front();
            checks++;
            if (rd_b_data !== e) begin failures++; $display("FAIL pattern_rd_b[%0d] got %h want %h", (i + 7) % NREGS, rd_b_data, e); end
        end
    endtask

    task automatic test_flag_priority;
        logic [DATA_W-1:0] e;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'h12;
        flag_en = 1'b1; flag_data = 8'h01;
        tick();
        model[15] = 8'h01;
        wr_addr = 4'd5; wr_data = 8'h5A; flag_data = 8'h80;
        rd_a_addr = 4'd15;
        exp_a_q.push_back(model[15]);
        tick();
        model[5] = 8'h5A;
        model[15] = 8'h80;
        wr_en = 1'b0; flag_en = 1'b0;
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL flag_beats_wr got %h want %h", rd_a_data, e); end
        rd_a_addr = 4'd15; rd_b_addr = 4'd5;
        exp_a_q.push_back(model[15]);
        exp_b_q.push_back(model[5]);
        tick();
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL flag_second got %h want %h", rd_a_data, e); end
        e = exp_b_q.pop_front();
        checks++;
        if (rd_b_data !== e) begin failures++; $display("FAIL flag_side_wr got %h want %h", rd_b_data, e); end
    endtask

    task automatic test_raw;
        logic [DATA_W-1:0] e;
        write_reg(2, 8'h10);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
        flag_en = 1'b1; flag_data = 8'h3C;
        rd_a_addr = 4'd2; rd_b_addr = 4'd15;
`ifdef REGFILE_BYPASS_EN
        exp_a_q.push_back(8'h77);
        exp_b_q.push_back(8'h3C);
`else
        exp_a_q.push_back(model[2]);
        exp_b_q.push_back(model[15]);
`endif
        tick();
        model[2] = 8'h77;
        model[15] = 8'h3C;
        wr_en = 1'b0; flag_en = 1'b0;
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL raw_same_cycle got %h want %h", rd_a_data, e); end
        e = exp_b_q.pop_front();
        checks++;
        if (rd_b_data !== e) begin failures++; $display("FAIL raw_flag_same_cycle got %h want %h", rd_b_data, e); end
        exp_a_q.push_back(model[2]);
        tick();
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL raw_next_cycle got %h want %h", rd_a_data, e); end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] e, d;
        int prev;
        for (int i = 0; i < NREGS; i++) begin
            d = 8'($urandom_range(0, 255));
            prev = (i + NREGS - 1) % NREGS;
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = d;
            rd_a_addr = ADDR_W'(prev); rd_b_addr = ADDR_W'(i);
            exp_a_q.push_back(model[prev]);
`ifdef REGFILE_BYPASS_EN
            exp_b_q.push_back(d);
`else
            exp_b_q.push_back(model[i]);
`endif
            tick();
            model[i] = d;
            e = exp_a_q.pop_front();
            checks++;
            if (rd_a_data !== e) begin failures++; $display("FAIL b2b_rd_a[%0d] got %h want %h", prev, rd_a_data, e); end
            e = exp_b_q.pop_front();
            checks++;
            if (rd_b_data !== e) begin failures++; $display("FAIL b2b_rd_b[%0d] got %h want %h", i, rd_b_data, e); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_dump;
        logic [ADDR_W+DATA_W-1:0] eb;
        logic [ADDR_W-1:0] hidx;
        logic [DATA_W-1:0] hdat;
        logic held;
        logic [4:0] seq;
        int k, dones, beats;
        seq = 5'b11101;
        for (int i = 0; i < 4; i++) write_reg(i, 8'(i + 1));
        dump_start = 1'b1; dump_last = 4'd3; dump_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_beat_q.push_back({ADDR_W'(i), model[i]});
        tick();
        dump_start = 1'b0;
        checks++;
        if (dump_valid !== 1'b1 || dump_busy !== 1'b1) begin
            failures++; $display("FAIL dump_first_beat got valid=%b busy=%b want 1 1", dump_valid, dump_busy);
        end
        dones = 0; beats = 0; k = 0;
        while (k < 40) begin
            dump_ready = (k < 5) ? seq[k] : 1'b1;
            wr_en = (k == 1); wr_addr = 4'd1; wr_data = 8'h99;
            dump_start = (k == 2); dump_last = 4'd0;
            if (dump_valid && dump_ready) begin
                beats++;
                checks++;
                if (exp_beat_q.size() == 0) begin
                    failures++; $display("FAIL dump_extra_beat got idx=%0d data=%h want no beat", dump_idx, dump_data);
                end else begin
                    eb = exp_beat_q.pop_front();
                    if ({dump_idx, dump_data} !== eb) begin
                        failures++; $display("FAIL dump_beat got (%0d,%h) want (%0d,%h)", dump_idx, dump_data, eb[ADDR_W+DATA_W-1:DATA_W], eb[DATA_W-1:0]);
                    end
                end
            end
            held = dump_valid && !dump_ready;
            hidx = dump_idx; hdat = dump_data;
            tick();
            if (k == 1) model[1] = 8'h99;
            wr_en = 1'b0; dump_start = 1'b0;
            if (held) begin
                checks++;
                if (dump_valid !== 1'b1 || dump_idx !== hidx || dump_data !== hdat) begin
                    failures++; $display("FAIL dump_hold got v=%b (%0d,%h) want v=1 (%0d,%h)", dump_valid, dump_idx, dump_data, hidx, hdat);
                end
            end
            if (dump_done) dones++;
            k++;
            if (!dump_busy) break;
        end
        checks++;
        if (k >= 40) begin failures++; $display("FAIL dump_timeout got busy=%b want 0 within 40 cycles", dump_busy); end
        checks++;
        if (dones !== 1) begin failures++; $display("FAIL dump_done_count got %0d want 1", dones); end
        checks++;
        if (beats !== 4 || exp_beat_q.size() !== 0) begin
            failures++; $display("FAIL dump_beat_count got %0d beats (%0d left) want 4 (0 left)", beats, exp_beat_q.size());
        end
        exp_beat_q.delete();
    endtask

    task automatic test_abort;
        logic [ADDR_W+DATA_W-1:0] eb;
        logic [DATA_W-1:0] e;
        logic found;
        found = 1'b0;
        dump_start = 1'b1; dump_last = 4'd5; dump_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_beat_q.push_back({ADDR_W'(i), model[i]});
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (dump_valid && dump_idx == 4'd2) begin
                found = 1'b1;
            end else begin
                if (dump_valid) begin
                    eb = exp_beat_q.pop_front();
                    checks++;
                    if ({dump_idx, dump_data} !== eb) begin
                        failures++; $display("FAIL abort_beat got (%0d,%h) want (%0d,%h)", dump_idx, dump_data, eb[ADDR_W+DATA_W-1:DATA_W], eb[DATA_W-1:0]);
                    end
                end
                tick();
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL abort_reach_idx2 got idx=%0d valid=%b want idx 2 valid", dump_idx, dump_valid); end
        clr = 1'b1;
        rd_a_addr = 4'd0;
`ifdef REGFILE_BYPASS_EN
        exp_a_q.push_back(8'h00);
`else
        exp_a_q.push_back(model[0]);
`endif
        tick();
        clr = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            failures++; $display("FAIL abort_state got valid=%b busy=%b done=%b want 0 0 0", dump_valid, dump_busy, dump_done);
        end
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e) begin failures++; $display("FAIL abort_clr_read got %h want %h", rd_a_data, e); end
        exp_beat_q.delete();
        for (int i = 0; i < NREGS; i++) begin
            rd_a_addr = ADDR_W'(i);
            exp_a_q.push_back(model[i]);
            tick();
            e = exp_a_q.pop_front();
            checks++;
            if (rd_a_data !== e || dump_done !== 1'b0) begin
                failures++; $display("FAIL abort_cleared[%0d] got %h done=%b want %h done=0", i, rd_a_data, dump_done, e);
            end
        end
    endtask

    task automatic test_reset_mid_dump;
        logic [DATA_W-1:0] e;
        write_reg(3, 8'hC3);
        dump_start = 1'b1; dump_last = 4'd3; dump_ready = 1'b0;
        tick();
        dump_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 4'd0 || dump_data !== 8'h00 || rd_a_data !== 8'h00) begin
            failures++; $display("FAIL reset_mid_dump got valid=%b busy=%b idx=%0d data=%h rd_a=%h want all 0", dump_valid, dump_busy, dump_idx, dump_data, rd_a_data);
        end
        tick();
        rst_n = 1'b1;
        dump_ready = 1'b1;
        rd_a_addr = 4'd3;
        exp_a_q.push_back(model[3]);
        tick();
        e = exp_a_q.pop_front();
        checks++;
        if (rd_a_data !== e || dump_done !== 1'b0 || dump_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_dump_after got v3=%h done=%b valid=%b want %h 0 0", rd_a_data, dump_done, dump_valid, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_flag_priority();
        test_raw();
        test_back_to_back();
        test_dump();
        test_abort();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
